// File: rtl/fft_bin_collector.sv
// Collects eight complex FFT bins delivered in index order into a frame,
// tracking the bin with the largest |re|+|im| as samples arrive.
module fft_bin_collector (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   in_re,
   input  logic [15:0]   in_im,
   input  logic [2:0]    in_index,
   input  logic          in_valid,
   output logic [127:0]  frame_re,
   output logic [127:0]  frame_im,
   output logic          frame_valid,
   output logic [2:0]    peak_index,
   output logic [16:0]   peak_mag,
   output logic          seq_error
);

   typedef enum logic {IDLE, COLLECT} state_t;

   state_t        state;
   logic [2:0]    expected;
   logic [127:0]  work_re, work_im;
   logic [127:0]  ins_re, ins_im;
   logic [2:0]    run_idx, nxt_idx;
   logic [16:0]   run_mag, nxt_mag;
   logic [16:0]   in_mag;

   // 17-bit absolute value so that |-32768| = 32768 is representable
   function automatic logic [16:0] abs16(input logic [15:0] v);
      logic [16:0] s;
      s = {v[15], v};
      return s[16] ? (~s + 17'd1) : s;
   endfunction

   assign in_mag = abs16(in_re) + abs16(in_im);

   // Working buffer with the incoming sample already placed, so the final
   // bin can be copied into the presented frame on the same edge.
   always_comb begin
      ins_re = work_re;
      ins_im = work_im;
      ins_re[{in_index, 4'b0000} +: 16] = in_re;
      ins_im[{in_index, 4'b0000} +: 16] = in_im;
      if (in_mag > run_mag) begin
         nxt_idx = in_index;
         nxt_mag = in_mag;
      end else begin
         nxt_idx = run_idx;
         nxt_mag = run_mag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         expected    <= '0;
         work_re     <= '0;
         work_im     <= '0;
         run_idx     <= '0;
         run_mag     <= '0;
         frame_re    <= '0;
         frame_im    <= '0;
         frame_valid <= 1'b0;
         peak_index  <= '0;
         peak_mag    <= '0;
         seq_error   <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         seq_error   <= 1'b0;
         if (in_valid) begin
            case (state)
               IDLE: begin
                  if (in_index == 3'd0) begin
                     work_re  <= ins_re;
                     work_im  <= ins_im;
                     run_idx  <= 3'd0;
                     run_mag  <= in_mag;
                     expected <= 3'd1;
                     state    <= COLLECT;
                  end
               end
               COLLECT: begin
                  if (in_index == expected) begin
                     work_re <= ins_re;
                     work_im <= ins_im;
                     run_idx <= nxt_idx;
                     run_mag <= nxt_mag;
                     if (expected == 3'd7) begin
                        frame_re    <= ins_re;
                        frame_im    <= ins_im;
                        peak_index  <= nxt_idx;
                        peak_mag    <= nxt_mag;
                        frame_valid <= 1'b1;
                        expected    <= '0;
                        state       <= IDLE;
                     end else begin
                        expected <= expected + 3'd1;
                     end
                  end else begin
                     seq_error <= 1'b1;
                     // An out-of-order bin 0 starts a fresh frame immediately
                     if (in_index == 3'd0) begin
                        work_re  <= ins_re;
                        work_im  <= ins_im;
                        run_idx  <= 3'd0;
                        run_mag  <= in_mag;
                        expected <= 3'd1;
                     end else begin
                        expected <= '0;
                        state    <= IDLE;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
